// File: rtl/ysyx_25060170_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25060170_pkg
// Purpose  : Shared RV32I decode definitions for the NPC decode stage.
//            Holds opcode constants, immediate-format enum and the
//            control half of the decoded bundle.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_25060170_pkg;

  // Major opcodes (inst[6:0]) of the RV32I base ISA
  localparam logic [6:0] c_opc_lui      = 7'b0110111;
  localparam logic [6:0] c_opc_auipc    = 7'b0010111;
  localparam logic [6:0] c_opc_jal      = 7'b1101111;
  localparam logic [6:0] c_opc_jalr     = 7'b1100111;
  localparam logic [6:0] c_opc_branch   = 7'b1100011;
  localparam logic [6:0] c_opc_load     = 7'b0000011;
  localparam logic [6:0] c_opc_store    = 7'b0100011;
  localparam logic [6:0] c_opc_op_imm   = 7'b0010011;
  localparam logic [6:0] c_opc_op       = 7'b0110011;
  localparam logic [6:0] c_opc_misc_mem = 7'b0001111;
  localparam logic [6:0] c_opc_system   = 7'b1110011;

  // The only two SYSTEM encodings this core accepts
  localparam logic [31:0] c_inst_ecall  = 32'h0000_0073;
  localparam logic [31:0] c_inst_ebreak = 32'h0010_0073;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  // XLEN-independent part of the decoded bundle
  typedef struct packed {
    logic [4:0] rd;
    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic       is_ebreak;
    logic       is_ecall;
    logic       illegal;
  } dec_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/ysyx_25060170_idu_dec.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25060170_idu_dec
// Purpose  : Combinational RV32I decoder: immediates, operand selection,
//            legality check and SYSTEM flags.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25060170_idu_dec
  import ysyx_25060170_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int PC_INCR = 4
) (
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] op_1,
  output logic [XLEN-1:0] op_2,
  output logic [XLEN-1:0] op_3,
  output logic [XLEN-1:0] op_4,
  output dec_ctrl_t       ctrl
);

  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm32;
  imm_type_e   w_imm_type;
  logic        w_illegal, w_ecall, w_ebreak;
  logic        w_op1_pc, w_op1_rs1, w_op2_imm, w_op2_rs2, w_link;

  assign w_opc = inst[6:0];
  assign w_f3  = inst[14:12];
  assign w_f7  = inst[31:25];

  assign w_imm_i = {{20{inst[31]}}, inst[31:20]};
  assign w_imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign w_imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign w_imm_u = {inst[31:12], 12'b0};
  assign w_imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  assign w_ecall  = (inst == c_inst_ecall);
  assign w_ebreak = (inst == c_inst_ebreak);

  // Classify the opcode: immediate format, operand sources and legality
  always_comb begin
    w_imm_type = IMM_NONE;
    w_illegal  = 1'b0;
    w_op1_pc   = 1'b0;
    w_op1_rs1  = 1'b0;
    w_op2_imm  = 1'b0;
    w_op2_rs2  = 1'b0;
    w_link     = 1'b0;
    case (w_opc)
      c_opc_lui: begin
        w_imm_type = IMM_U;
        w_op2_imm  = 1'b1;
      end
      c_opc_auipc: begin
        w_imm_type = IMM_U;
        w_op1_pc   = 1'b1;
        w_op2_imm  = 1'b1;
      end
      c_opc_jal: begin
        w_imm_type = IMM_J;
        w_op1_pc   = 1'b1;
        w_op2_imm  = 1'b1;
        w_link     = 1'b1;
      end
      c_opc_jalr: begin
        w_imm_type = IMM_I;
        w_op1_rs1  = 1'b1;
        w_op2_imm  = 1'b1;
        w_link     = 1'b1;
        w_illegal  = (w_f3 != 3'b000);
      end
      c_opc_branch: begin
        w_imm_type = IMM_B;
        w_op1_pc   = 1'b1;
        w_op2_imm  = 1'b1;
        w_illegal  = (w_f3 == 3'b010) || (w_f3 == 3'b011);
      end
      c_opc_load: begin
        w_imm_type = IMM_I;
        w_op1_rs1  = 1'b1;
        w_op2_imm  = 1'b1;
        w_illegal  = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
      end
      c_opc_store: begin
        w_imm_type = IMM_S;
        w_op1_rs1  = 1'b1;
        w_op2_imm  = 1'b1;
        w_illegal  = (w_f3 >= 3'b011);
      end
      c_opc_op_imm: begin
        w_imm_type = IMM_I;
        w_op1_rs1  = 1'b1;
        w_op2_imm  = 1'b1;
        if (w_f3 == 3'b001)
          w_illegal = (w_f7 != 7'b0000000);
        else if (w_f3 == 3'b101)
          w_illegal = (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000);
      end
      c_opc_op: begin
        w_op1_rs1 = 1'b1;
        w_op2_rs2 = 1'b1;
        w_illegal = ((w_f7 != 7'b0000000) && (w_f7 != 7'b0100000)) ||
                    ((w_f7 == 7'b0100000) && (w_f3 != 3'b000) && (w_f3 != 3'b101));
      end
      c_opc_misc_mem: begin
        w_illegal = 1'b0;
      end
      c_opc_system: begin
        w_illegal = !(w_ecall || w_ebreak);
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  // Select the 32-bit immediate for the decoded format
  always_comb begin
    w_imm32 = 32'b0;
    case (w_imm_type)
      IMM_I:   w_imm32 = w_imm_i;
      IMM_S:   w_imm32 = w_imm_s;
      IMM_B:   w_imm32 = w_imm_b;
      IMM_U:   w_imm32 = w_imm_u;
      IMM_J:   w_imm32 = w_imm_j;
      default: w_imm32 = 32'b0;
    endcase
  end

  if (XLEN == 32) begin : g_imm_xlen32
    assign imm = w_imm32;
  end else begin : g_imm_wide
    assign imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
  end

  // Build operands; illegal instructions carry all-zero operands
  always_comb begin
    op_1 = '0;
    op_2 = '0;
    op_3 = '0;
    op_4 = '0;
    if (!w_illegal) begin
      if (w_op1_pc)  op_1 = pc;
      if (w_op1_rs1) op_1 = rs1_data;
      if (w_op2_imm) op_2 = imm;
      if (w_op2_rs2) op_2 = rs2_data;
      if (w_link) begin
        op_3 = pc;
        op_4 = XLEN'(PC_INCR);
      end
    end
  end

  assign ctrl = '{
    rd:        inst[11:7],
    opcode:    w_opc,
    funct7:    w_f7,
    funct3:    w_f3,
    is_ebreak: w_ebreak,
    is_ecall:  w_ecall,
    illegal:   w_illegal
  };

endmodule
`default_nettype wire

// File: rtl/ysyx_25060170_idu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25060170_idu_pipe
// Purpose  : Registered IDU stage: valid/ready input, decode at accept,
//            output register with one-entry skid buffer, flush and a
//            saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25060170_idu_pipe
  import ysyx_25060170_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int PC_INCR = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [31:0]      inst_i,
  output logic [4:0]       rs1_raddr_o,
  output logic [4:0]       rs2_raddr_o,
  input  logic [XLEN-1:0]  reg1_rdata_i,
  input  logic [XLEN-1:0]  reg2_rdata_i,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  imm_o,
  output logic [XLEN-1:0]  rs1_data_o,
  output logic [XLEN-1:0]  rs2_data_o,
  output logic [XLEN-1:0]  op_1,
  output logic [XLEN-1:0]  op_2,
  output logic [XLEN-1:0]  op_3,
  output logic [XLEN-1:0]  op_4,
  output logic [4:0]       rd_addr,
  output logic [6:0]       opcode,
  output logic [6:0]       funct7,
  output logic [2:0]       funct3,
  output logic             is_ebreak,
  output logic             is_ecall,
  output logic             illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] op3;
    logic [XLEN-1:0] op4;
    dec_ctrl_t       ctrl;
  } bundle_t;

  logic [XLEN-1:0]  w_imm, w_op1, w_op2, w_op3, w_op4;
  dec_ctrl_t        w_ctrl;
  bundle_t          w_new;
  bundle_t          r_out, r_skid;
  logic             r_out_valid, r_skid_valid;
  logic             w_accept, w_load_out;
  logic [CNT_W-1:0] r_stall_cnt;

  assign rs1_raddr_o = inst_i[19:15];
  assign rs2_raddr_o = inst_i[24:20];

  ysyx_25060170_idu_dec #(
    .XLEN    (XLEN),
    .PC_INCR (PC_INCR)
  ) u_dec (
    .inst     (inst_i),
    .pc       (pc_i),
    .rs1_data (reg1_rdata_i),
    .rs2_data (reg2_rdata_i),
    .imm      (w_imm),
    .op_1     (w_op1),
    .op_2     (w_op2),
    .op_3     (w_op3),
    .op_4     (w_op4),
    .ctrl     (w_ctrl)
  );

  assign w_new = '{
    pc:   pc_i,
    imm:  w_imm,
    rs1:  reg1_rdata_i,
    rs2:  reg2_rdata_i,
    op1:  w_op1,
    op2:  w_op2,
    op3:  w_op3,
    op4:  w_op4,
    ctrl: w_ctrl
  };

  // in_ready depends only on skid occupancy, never on out_ready
  assign in_ready   = !r_skid_valid;
  assign w_accept   = in_valid && in_ready;
  assign w_load_out = !r_out_valid || out_ready;

  // Output register plus skid entry; flush empties both and wins over loads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out        <= '0;
      r_skid       <= '0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_load_out) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out        <= w_new;
        r_out_valid  <= 1'b1;
      end else begin
        r_out_valid  <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid       <= w_new;
      r_skid_valid <= 1'b1;
    end
  end

  // Count cycles where EXU back-pressures a valid bundle; sticks at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign out_valid  = r_out_valid;
  assign pc_o       = r_out.pc;
  assign imm_o      = r_out.imm;
  assign rs1_data_o = r_out.rs1;
  assign rs2_data_o = r_out.rs2;
  assign op_1       = r_out.op1;
  assign op_2       = r_out.op2;
  assign op_3       = r_out.op3;
  assign op_4       = r_out.op4;
  assign rd_addr    = r_out.ctrl.rd;
  assign opcode     = r_out.ctrl.opcode;
  assign funct7     = r_out.ctrl.funct7;
  assign funct3     = r_out.ctrl.funct3;
  assign is_ebreak  = r_out.ctrl.is_ebreak;
  assign is_ecall   = r_out.ctrl.is_ecall;
  assign illegal    = r_out.ctrl.illegal;
  assign stall_cnt  = r_stall_cnt;

endmodule
`default_nettype wire
